alu_cmp_unit: RTL and testbench



---
 rtl/riscv_structures.sv | 27 ++
 rtl/alu.sv | 39 +++
 rtl/compare.sv | 33 +++
 rtl/alu_cmp_unit.sv | 65 ++++++
 tb/tb_alu_cmp_unit.sv | 144 ++++++++++++++
 5 files changed

// File: rtl/riscv_structures.sv
// Shared RV32I execute-stage definitions.
//   alu_op_e : 4-bit ALU operation select, encoded as {funct7[5], funct3}
//   F3_*     : branch funct3 codes used by the comparator
package riscv_structures;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'b0000,
    ALU_SLL   = 4'b0001,
    ALU_SLT   = 4'b0010,
    ALU_SLTU  = 4'b0011,
    ALU_XOR   = 4'b0100,
    ALU_SRL   = 4'b0101,
    ALU_OR    = 4'b0110,
    ALU_AND   = 4'b0111,
    ALU_SUB   = 4'b1000,
    ALU_SRA   = 4'b1101,
    ALU_PASSB = 4'b1111
  } alu_op_e;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/alu.sv
// 32-bit RV32I integer ALU, purely combinational, no flags.
//   in1    : operand A (rs1 or PC)
//   in2    : operand B (rs2 or immediate); shifts use in2[4:0] only
//   alu_op : alu_op_e code; unknown codes give result = 0
//   result : operation result, modulo 2^32
module alu
  import riscv_structures::*;
(
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  input  logic [3:0]  alu_op,
  output logic [31:0] result
);

  alu_op_e    op;
  logic [4:0] shamt;

  assign op    = alu_op_e'(alu_op);
  assign shamt = in2[4:0];

  always_comb begin
    result = 32'd0;
    case (op)
      ALU_ADD:   result = in1 + in2;
      ALU_SUB:   result = in1 - in2;
      ALU_SLL:   result = in1 << shamt;
      ALU_SLT:   result = {31'd0, $signed(in1) < $signed(in2)};
      ALU_SLTU:  result = {31'd0, in1 < in2};
      ALU_XOR:   result = in1 ^ in2;
      ALU_SRL:   result = in1 >> shamt;
      ALU_SRA:   result = $unsigned($signed(in1) >>> shamt);
      ALU_OR:    result = in1 | in2;
      ALU_AND:   result = in1 & in2;
      ALU_PASSB: result = in2;
      default:   result = 32'd0;
    endcase
  end

endmodule

// File: rtl/compare.sv
// Branch-condition comparator, purely combinational.
//   in1, in2 : comparator operands (rs1, rs2)
//   funct3   : branch funct3; 010/011 give cond = 0
//   cond     : branch condition, evaluated every cycle regardless of opcode
module compare
  import riscv_structures::*;
(
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  input  logic [2:0]  funct3,
  output logic        cond
);

  logic eq, lt_s, lt_u;

  assign eq   = (in1 == in2);
  assign lt_s = ($signed(in1) < $signed(in2));
  assign lt_u = (in1 < in2);

  always_comb begin
    cond = 1'b0;
    case (funct3)
      F3_BEQ:  cond = eq;
      F3_BNE:  cond = !eq;
      F3_BLT:  cond = lt_s;
      F3_BGE:  cond = !lt_s;
      F3_BLTU: cond = lt_u;
      F3_BGEU: cond = !lt_u;
      default: cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_cmp_unit.sv
// RV32I execute-stage integer datapath: ALU + branch comparator with a
// one-stage output register for the EX/MEM hand-off.
//   clk, rst_n        : clock, asynchronous active-low reset
//   in1, in2, alu_op  : ALU operands and operation
//   cmp1, cmp2, funct3: comparator operands and branch funct3
//   valid             : operands belong to a live instruction (not a gate)
//   result, cond      : combinational outputs (used for redirect)
//   result_q, cond_q, valid_q : registered copies, 1-cycle latency
module alu_cmp_unit
  import riscv_structures::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  input  logic [31:0] cmp1,
  input  logic [31:0] cmp2,
  input  logic [3:0]  alu_op,
  input  logic [2:0]  funct3,
  input  logic        valid,
  output logic [31:0] result,
  output logic        cond,
  output logic [31:0] result_q,
  output logic        cond_q,
  output logic        valid_q
);

  logic [31:0] result_d;
  logic        cond_d;
  logic        valid_d;

  alu u_alu (
    .in1    (in1),
    .in2    (in2),
    .alu_op (alu_op),
    .result (result)
  );

  compare u_compare (
    .in1    (cmp1),
    .in2    (cmp2),
    .funct3 (funct3),
    .cond   (cond)
  );

  // No enable or stall: every edge captures the current combinational values.
  always_comb begin
    result_d = result;
    cond_d   = cond;
    valid_d  = valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= 32'd0;
      cond_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      result_q <= result_d;
      cond_q   <= cond_d;
      valid_q  <= valid_d;
    end
  end

endmodule

// File: tb/tb_alu_cmp_unit.sv
module tb_alu_cmp_unit;
  import riscv_structures::*;

  logic        clk;
  logic        rst_n;
  logic [31:0] in1, in2, cmp1, cmp2;
  logic [3:0]  alu_op;
  logic [2:0]  funct3;
  logic        valid;
  logic [31:0] result, result_q;
  logic        cond, cond_q, valid_q;

  int tests_run = 0;
  int tests_failed = 0;

  alu_cmp_unit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in1      (in1),
    .in2      (in2),
    .cmp1     (cmp1),
    .cmp2     (cmp2),
    .alu_op   (alu_op),
    .funct3   (funct3),
    .valid    (valid),
    .result   (result),
    .cond     (cond),
    .result_q (result_q),
    .cond_q   (cond_q),
    .valid_q  (valid_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  f3;
    logic [31:0] c1;
    logic [31:0] c2;
    logic [31:0] exp_result;
    logic        exp_cond;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end else begin
      $display("[TB] ok %s: 0x%08h", name, act);
    end
  endtask

  initial begin
    vecs[0]  = '{"add_ovf",   4'b0000, 32'h7FFFFFFF, 32'h1,        3'b000, 32'h0,        32'h0,        32'h80000000, 1'b1};
    vecs[1]  = '{"add_wrap",  4'b0000, 32'hFFFFFFFF, 32'h1,        3'b000, 32'h0,        32'h1,        32'h00000000, 1'b0};
    vecs[2]  = '{"sub_blt",   4'b1000, 32'h0,        32'h1,        3'b100, 32'hFFFFFFFF, 32'h1,        32'hFFFFFFFF, 1'b1};
    vecs[3]  = '{"slt_bltu",  4'b0010, 32'hFFFFFFFF, 32'h1,        3'b110, 32'hFFFFFFFF, 32'h1,        32'h00000001, 1'b0};
    vecs[4]  = '{"sltu_bge",  4'b0011, 32'hFFFFFFFF, 32'h1,        3'b101, 32'hFFFFFFFF, 32'h1,        32'h00000000, 1'b0};
    vecs[5]  = '{"sra_bgeu",  4'b1101, 32'h80000000, 32'h21,       3'b111, 32'hFFFFFFFF, 32'h1,        32'hC0000000, 1'b1};
    vecs[6]  = '{"srl_beq",   4'b0101, 32'h80000000, 32'h21,       3'b000, 32'h5,        32'h5,        32'h40000000, 1'b1};
    vecs[7]  = '{"sll_bne",   4'b0001, 32'h1,        32'h21,       3'b001, 32'h5,        32'h5,        32'h00000002, 1'b0};
    vecs[8]  = '{"passb_f2",  4'b1111, 32'hDEADBEEF, 32'h12345000, 3'b010, 32'hFFFFFFFF, 32'h1,        32'h12345000, 1'b0};
    vecs[9]  = '{"undef_f3",  4'b1001, 32'h5,        32'h3,        3'b011, 32'h1,        32'h1,        32'h00000000, 1'b0};
    vecs[10] = '{"xor_bne",   4'b0100, 32'hF0F0F0F0, 32'hFF00FF00, 3'b001, 32'hFFFFFFFF, 32'h1,        32'h0FF00FF0, 1'b1};
    vecs[11] = '{"or_bge",    4'b0110, 32'hF0F0F0F0, 32'h0F0F0000, 3'b101, 32'h1,        32'hFFFFFFFF, 32'hFFFFF0F0, 1'b1};
    vecs[12] = '{"and_bgeu",  4'b0111, 32'hF0F0F0F0, 32'hFF00FF00, 3'b111, 32'h1,        32'hFFFFFFFF, 32'hF000F000, 1'b0};
    vecs[13] = '{"slt_bltu2", 4'b0010, 32'h1,        32'hFFFFFFFF, 3'b110, 32'h1,        32'hFFFFFFFF, 32'h00000000, 1'b1};
    vecs[14] = '{"sll31_blt", 4'b0001, 32'h3,        32'h1F,       3'b100, 32'h1,        32'hFFFFFFFF, 32'h80000000, 1'b0};
    vecs[15] = '{"sra4_bge",  4'b1101, 32'h7FFFFFFF, 32'h4,        3'b101, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h07FFFFFF, 1'b1};

    rst_n = 1'b0; valid = 1'b0;
    in1 = '0; in2 = '0; cmp1 = '0; cmp2 = '0; alu_op = '0; funct3 = 3'b010;
    #2;
    check("rst_result_q", result_q, 32'h0);
    check("rst_cond_q", {31'd0, cond_q}, 32'h0);
    check("rst_valid_q", {31'd0, valid_q}, 32'h0);

    @(negedge clk);
    rst_n = 1'b1;

    // Combinational table.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      alu_op = vecs[i].op; in1 = vecs[i].a; in2 = vecs[i].b;
      funct3 = vecs[i].f3; cmp1 = vecs[i].c1; cmp2 = vecs[i].c2;
      valid  = 1'b0;
      #1;
      check({vecs[i].name, "_result"}, result, vecs[i].exp_result);
      check({vecs[i].name, "_cond"}, {31'd0, cond}, {31'd0, vecs[i].exp_cond});
    end

    // Registered path: ADD 3+4, BEQ 2==2, valid=1.
    @(negedge clk);
    alu_op = 4'b0000; in1 = 32'd3; in2 = 32'd4;
    funct3 = 3'b000; cmp1 = 32'd2; cmp2 = 32'd2; valid = 1'b1;
    @(posedge clk); #1;
    check("reg_result_q", result_q, 32'd7);
    check("reg_cond_q", {31'd0, cond_q}, 32'd1);
    check("reg_valid_q", {31'd0, valid_q}, 32'd1);

    // Async reset between edges clears immediately.
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_result_q", result_q, 32'h0);
    check("async_rst_cond_q", {31'd0, cond_q}, 32'h0);
    check("async_rst_valid_q", {31'd0, valid_q}, 32'h0);
    check("rst_comb_result", result, 32'd7);
    check("rst_comb_cond", {31'd0, cond}, 32'd1);

    // Held in reset across an edge.
    @(posedge clk); #1;
    check("hold_rst_result_q", result_q, 32'h0);
    check("hold_rst_valid_q", {31'd0, valid_q}, 32'h0);

    // Release between edges: nothing captured until next rising edge.
    #2;
    rst_n = 1'b1;
    #1;
    check("post_release_result_q", result_q, 32'h0);
    @(posedge clk); #1;
    check("recap_result_q", result_q, 32'd7);
    check("recap_cond_q", {31'd0, cond_q}, 32'd1);
    check("recap_valid_q", {31'd0, valid_q}, 32'd1);

    // valid travels independently of the data.
    valid = 1'b0; funct3 = 3'b001;
    @(posedge clk); #1;
    check("novalid_valid_q", {31'd0, valid_q}, 32'd0);
    check("novalid_result_q", result_q, 32'd7);
    check("novalid_cond_q", {31'd0, cond_q}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
